// File: rtl/fwd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_pkg
//  Purpose  : Shared definitions for the operand-forwarding scoreboard:
//             default register-file geometry, the "no bypass" select code,
//             the register index type and the bypass-select width helper.
//  Revision : 1.0  initial release
// ============================================================================
package fwd_pkg;

    localparam int NREG_DEFAULT = 32;
    localparam int REG_AW       = $clog2(NREG_DEFAULT);
    localparam int SEL_NONE     = 0;

    typedef logic [REG_AW-1:0] reg_idx_t;

    // Select code 0 means "regfile", codes 1..nfwd name a forwarding channel.
    function automatic int sel_width(input int nfwd);
        return (nfwd < 1) ? 1 : $clog2(nfwd + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_port_sel.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_port_sel
//  Purpose  : Bypass source selection for a single read port. Returns k+1 for
//             the lowest-numbered valid forwarding channel k whose destination
//             matches rs, or SEL_NONE when nothing matches. x0 never forwards.
//  Ports    : rs        in   source register index
//             fwd_rd    in   destination per forwarding channel (packed)
//             fwd_valid in   channel write-valid flags
//             sel       out  bypass mux select
//  Revision : 1.0  initial release
// ============================================================================
module fwd_port_sel
    import fwd_pkg::*;
#(
    parameter int NFWD = 2,
    parameter int AW   = REG_AW,
    parameter int SW   = sel_width(NFWD)
) (
    input  logic [AW-1:0]      rs,
    input  logic [NFWD*AW-1:0] fwd_rd,
    input  logic [NFWD-1:0]    fwd_valid,
    output logic [SW-1:0]      sel
);

    // Scan from the lowest-priority channel upward so the last assignment,
    // i.e. the lowest matching index, wins.
    always_comb begin
        sel = SW'(SEL_NONE);
        if (rs != '0) begin
            for (int k = NFWD - 1; k >= 0; k--) begin
                if (fwd_valid[k] && (fwd_rd[k*AW +: AW] == rs)) begin
                    sel = SW'(k + 1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fwd_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_scoreboard
//  Purpose  : Operand forwarding + hazard unit. Per read port picks the
//             highest-priority bypass channel; tracks in-flight multi-cycle
//             mul results with a per-register countdown and stalls issue on
//             RAW (pending source) or WAW (pending destination) hazards.
//  Ports    : clk, rst_n (async, active low)
//             rs, rs_used, fwd_rd, fwd_valid -> rv_sel (combinational)
//             issue_valid, issue_rd, issue_is_mul, flush -> stall, busy
//             stall_count : stall-cycle counter
//  Config   : FWD_SCOREBOARD_STATS_EN - when defined, stall_count counts
//             cycles with stall=1 and flush=0; otherwise it is tied to 0.
//  Revision : 1.0  initial release
// ============================================================================
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter  int NREG    = NREG_DEFAULT,
    parameter  int NRD     = 2,
    parameter  int NFWD    = 2,
    parameter  int MUL_LAT = 3,
    localparam int AW      = $clog2(NREG),
    localparam int SW      = sel_width(NFWD),
    localparam int CW      = $clog2(MUL_LAT + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NRD*AW-1:0]  rs,
    input  logic [NRD-1:0]     rs_used,
    input  logic [NFWD*AW-1:0] fwd_rd,
    input  logic [NFWD-1:0]    fwd_valid,
    output logic [NRD*SW-1:0]  rv_sel,
    input  logic               issue_valid,
    input  logic [AW-1:0]      issue_rd,
    input  logic               issue_is_mul,
    input  logic               flush,
    output logic               stall,
    output logic               busy,
    output logic [31:0]        stall_count
);

    // Countdown per architectural register; x0 has no storage.
    logic [CW-1:0]   r_cnt [1:NREG-1];
    logic [NREG-1:0] w_pend;
    logic            w_raw;
    logic            w_waw;
    logic            w_fire;

    // ------------------------------------------------------------------
    // Bypass selection, one instance per read port
    // ------------------------------------------------------------------
    for (genvar p = 0; p < NRD; p++) begin : g_port
        fwd_port_sel #(
            .NFWD (NFWD),
            .AW   (AW),
            .SW   (SW)
        ) u_sel (
            .rs        (rs[p*AW +: AW]),
            .fwd_rd    (fwd_rd),
            .fwd_valid (fwd_valid),
            .sel       (rv_sel[p*SW +: SW])
        );
    end

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    always_comb begin
        w_pend = '0;
        for (int r = 1; r < NREG; r++) begin
            w_pend[r] = (r_cnt[r] != '0);
        end
    end

    always_comb begin
        w_raw = 1'b0;
        for (int p = 0; p < NRD; p++) begin
            if (rs_used[p] && w_pend[rs[p*AW +: AW]]) begin
                w_raw = 1'b1;
            end
        end
    end

    // WAW: a later writer must not overtake a pending mul to the same reg.
    assign w_waw  = (issue_rd != '0) && w_pend[issue_rd];
    assign stall  = issue_valid && (w_raw || w_waw);
    assign w_fire = issue_valid && !stall;
    assign busy   = |w_pend;

    // ------------------------------------------------------------------
    // Scoreboard counters. A fire can only target a register whose count
    // is already zero (WAW stall), so load and decrement never collide.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 1; r < NREG; r++) begin
                r_cnt[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (flush) begin
                    r_cnt[r] <= '0;
                end else if (w_fire && issue_is_mul && (issue_rd == AW'(r))) begin
                    r_cnt[r] <= CW'(MUL_LAT);
                end else if (r_cnt[r] != '0) begin
                    r_cnt[r] <= r_cnt[r] - 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional stall statistics
    // ------------------------------------------------------------------
`ifdef FWD_SCOREBOARD_STATS_EN
    logic [31:0] r_stall_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= 32'd0;
        end else if (stall && !flush) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign stall_count = r_stall_count;
`else
    assign stall_count = 32'd0;
`endif

endmodule
`default_nettype wire
